chess_board_renderer: RTL

- Reader/consumer of the flattened 512-bit chess Layout bus that the board-state logic produces.
- On a refresh request, snapshots Layout, then streams one full 240x320 RGB565 frame to the LT24 LCD pixel interface using a valid/ready handshake.
- Draws squares, piece glyphs and the cursor/lock highlights encoded in each square byte.

---
 rtl/chess_board_renderer_pkg.sv | 42 ++++
 rtl/chess_board_renderer_if.sv | 11 +
 rtl/chess_board_renderer_glyph_rom.sv | 33 +++
 rtl/chess_board_renderer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/chess_board_renderer_pkg.sv
// Shared constants and types for the chess board renderer: board geometry,
// square-byte field positions, palette and FSM state encoding.
package chess_board_renderer_pkg;

  localparam int CHESS_SQUARES = 64;
  localparam int SQUARE_WIDTH  = 8;
  localparam int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH;
  localparam int SQUARE_PIXELS = 30;
  localparam int BOARD_PIXELS  = 8 * SQUARE_PIXELS;
  localparam int LCD_WIDTH     = 240;
  localparam int LCD_HEIGHT    = 320;
  localparam int GLYPH_OFFSET  = 7;
  localparam int GLYPH_SIZE    = 16;
  localparam int RING_WIDTH    = 2;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    PAWN    = 3'd1,
    KNIGHT  = 3'd2,
    ROOK    = 3'd3,
    BISHOP  = 3'd4,
    QUEEN   = 3'd5,
    KING    = 3'd6,
    INVALID = 3'd7
  } chessman_t;

  localparam int OWNER_BIT   = 3;
  localparam int CURSOR_BIT  = 4;
  localparam int LOCK_BIT    = 5;
  localparam int LOCKCUR_BIT = 6;

  localparam logic [15:0] COLOUR_WHITE   = 16'hFFFF;
  localparam logic [15:0] COLOUR_BLACK   = 16'h0000;
  localparam logic [15:0] COLOUR_LOCKCUR = 16'hF800;
  localparam logic [15:0] COLOUR_LOCK    = 16'h07E0;
  localparam logic [15:0] COLOUR_CURSOR  = 16'h001F;
  localparam logic [15:0] COLOUR_LIGHT   = 16'hEF5D;
  localparam logic [15:0] COLOUR_DARK    = 16'h8A22;

  typedef enum logic [1:0] {IDLE, SNAP, DRAW, DONE} state_t;

endpackage

// File: rtl/chess_board_renderer_if.sv
// LT24 pixel-write channel: the renderer offers a pixel, the LCD accepts it.
interface chess_board_renderer_if;
  logic        pixelWrite;
  logic [15:0] pixelData;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic        pixelReady;

  modport master (output pixelWrite, pixelData, xAddr, yAddr, input pixelReady);
  modport slave  (input pixelWrite, pixelData, xAddr, yAddr, output pixelReady);
endinterface

// File: rtl/chess_board_renderer_glyph_rom.sv
// 16x16 monochrome piece glyphs; row gy is a 16-bit word, leftmost pixel in bit 15.
module chess_glyph_rom
  import chess_board_renderer_pkg::*;
(
  input  logic [2:0] chessman,
  input  logic [3:0] gy,
  input  logic [3:0] gx,
  output logic       glyph_bit
);

  logic [0:15][15:0] glyph;

  always_comb begin
    case (chessman)
      PAWN:    glyph = {16'h0000, 16'h0000, 16'h0000, 16'h0180, 16'h03C0, 16'h03C0, 16'h0180, 16'h03C0,
                        16'h07E0, 16'h03C0, 16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h7FFE, 16'h0000};
      KNIGHT:  glyph = {16'h0000, 16'h0000, 16'h0300, 16'h07C0, 16'h0FE0, 16'h1FF0, 16'h3EF0, 16'h3CF0,
                        16'h01F0, 16'h03F0, 16'h07E0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h7FFE, 16'h0000};
      ROOK:    glyph = {16'h0000, 16'h0000, 16'h1998, 16'h1998, 16'h1FF8, 16'h0FF0, 16'h07E0, 16'h07E0,
                        16'h07E0, 16'h07E0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'h0000};
      BISHOP:  glyph = {16'h0000, 16'h0180, 16'h03C0, 16'h0660, 16'h0E70, 16'h0FF0, 16'h0FF0, 16'h07E0,
                        16'h03C0, 16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'h0000};
      QUEEN:   glyph = {16'h0000, 16'h1248, 16'h1248, 16'h1FF8, 16'h1FF8, 16'h0FF0, 16'h0FF0, 16'h07E0,
                        16'h07E0, 16'h07E0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'h0000};
      KING:    glyph = {16'h0000, 16'h0180, 16'h07E0, 16'h0180, 16'h0180, 16'h1DB8, 16'h3FFC, 16'h3FFC,
                        16'h1FF8, 16'h0FF0, 16'h07E0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h7FFE, 16'h0000};
      default: glyph = '0;
    endcase
  end

  assign glyph_bit = glyph[gy][4'd15 - gx];

endmodule

// File: rtl/chess_board_renderer.sv
// Snapshots the board Layout on refresh and streams one 240x320 RGB565 frame
// over a valid/ready pixel channel, drawing squares, glyphs and highlights.
module chess_board_renderer
  import chess_board_renderer_pkg::*;
(
  input  logic                    clock,
  input  logic                    resetApp,
  input  logic [MATRIX_WIDTH-1:0] Layout,
  input  logic                    refresh,
  chess_board_renderer_if.master  lcd,
  output logic                    frameBusy,
  output logic                    frameDone
);

  localparam logic [4:0] SQ_LAST = 5'(SQUARE_PIXELS - 1);
  localparam logic [7:0] X_LAST  = 8'(LCD_WIDTH - 1);
  localparam logic [8:0] Y_LAST  = 9'(LCD_HEIGHT - 1);
  localparam logic [8:0] Y_BOARD = 9'(BOARD_PIXELS);
  localparam logic [4:0] G_LO    = 5'(GLYPH_OFFSET);
  localparam logic [4:0] G_HI    = 5'(GLYPH_OFFSET + GLYPH_SIZE - 1);
  localparam logic [4:0] RING_LO = 5'(RING_WIDTH);
  localparam logic [4:0] RING_HI = 5'(SQUARE_PIXELS - RING_WIDTH);

  state_t                  state, state_next;
  logic                    pending, load, accept, last;
  logic [MATRIX_WIDTH-1:0] snapshot, board;
  logic [7:0]              x, x_n;
  logic [8:0]              y, y_n;
  logic [4:0]              px, py, px_n, py_n;
  logic [2:0]              col, row, col_n, row_n;
  logic [6:0]              sq;
  logic                    in_glyph, ring, glyph_bit;
  logic [15:0]             data_n;

  // NOTE: sequential state uses non-blocking assignments and the async reset
  // sits in the sensitivity list, so outputs clear without waiting for a clock.
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) state <= IDLE;
    else           state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (refresh || pending) state_next = SNAP;
      SNAP:    state_next = DRAW;
      DRAW:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lcd.pixelWrite = (state == DRAW);
    frameBusy      = (state != IDLE);
    frameDone      = (state == DONE);
    load           = (state == SNAP);
    accept         = (state == DRAW) && lcd.pixelReady;
  end

  assign last = accept && (x == X_LAST) && (y == Y_LAST);

  // Requests arriving mid-frame collapse into a single follow-up frame.
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp)           pending <= 1'b0;
    else if (state == IDLE)  pending <= 1'b0;
    else if (refresh)        pending <= 1'b1;
  end

  // NOTE: the snapshot is an ordinary flop bank, so it takes the reset like any register.
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) snapshot <= '0;
    else if (load) snapshot <= Layout;
  end

  // Raster walk with per-square sub-counters, so no divider is needed.
  always_comb begin
    x_n   = x + 8'd1;
    y_n   = y;
    px_n  = px + 5'd1;
    col_n = col;
    py_n  = py;
    row_n = row;
    if (load) begin
      x_n = '0; y_n = '0; px_n = '0; col_n = '0; py_n = '0; row_n = '0;
    end else begin
      if (px == SQ_LAST) begin
        px_n  = '0;
        col_n = col + 3'd1;
      end
      if (x == X_LAST) begin
        x_n   = '0;
        px_n  = '0;
        col_n = '0;
        y_n   = y + 9'd1;
        py_n  = py + 5'd1;
        if (py == SQ_LAST) begin
          py_n  = '0;
          row_n = row + 3'd1;
        end
        if (y == Y_LAST) begin
          y_n = '0; py_n = '0; row_n = '0;
        end
      end
    end
  end

  // During SNAP the snapshot is still loading, so pixel (0,0) reads Layout directly.
  assign board    = load ? Layout : snapshot;
  assign sq       = board[{row_n, col_n, 3'b000} +: 7];
  assign in_glyph = (px_n >= G_LO) && (px_n <= G_HI) && (py_n >= G_LO) && (py_n <= G_HI);
  assign ring     = (px_n < RING_LO) || (px_n >= RING_HI) || (py_n < RING_LO) || (py_n >= RING_HI);

  chess_glyph_rom u_rom (
    .chessman  (sq[2:0]),
    .gy        (py_n[3:0] - G_LO[3:0]),
    .gx        (px_n[3:0] - G_LO[3:0]),
    .glyph_bit (glyph_bit)
  );

  always_comb begin
    if (y_n >= Y_BOARD)               data_n = COLOUR_BLACK;
    else if (in_glyph && glyph_bit)   data_n = sq[OWNER_BIT] ? COLOUR_WHITE : COLOUR_BLACK;
    else if (ring && sq[LOCKCUR_BIT]) data_n = COLOUR_LOCKCUR;
    else if (ring && sq[LOCK_BIT])    data_n = COLOUR_LOCK;
    else if (ring && sq[CURSOR_BIT])  data_n = COLOUR_CURSOR;
    else if (row_n[0] ^ col_n[0])     data_n = COLOUR_DARK;
    else                              data_n = COLOUR_LIGHT;
  end

  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) begin
      x <= '0; y <= '0; px <= '0; py <= '0; col <= '0; row <= '0;
      lcd.pixelData <= '0;
    end else if (load || accept) begin
      x   <= x_n;   y   <= y_n;
      px  <= px_n;  py  <= py_n;
      col <= col_n; row <= row_n;
      lcd.pixelData <= data_n;
    end
  end

  assign lcd.xAddr = x;
  assign lcd.yAddr = y;

endmodule
